// File: rtl/bcsr_step_ctrl_if.sv
// Control/status bundle between a host and the circular shift register sequencer.
// The 'loop' request exists only when BCSR_STEP_CTRL_LOOP_EN is defined.
interface bcsr_step_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int STEPW = 8
);
`ifdef BCSR_STEP_CTRL_LOOP_EN
    logic             loop;
`endif
    logic             start;
    logic             abort;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] pattern;
    logic [STEPW-1:0] steps;

    logic             pre;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             shift_dir;
    logic [WIDTH-1:0] shadow;
    logic             busy;
    logic             done;

    modport master (
`ifdef BCSR_STEP_CTRL_LOOP_EN
        output loop,
`endif
        output start, abort, pause, dir, pattern, steps,
        input  pre, load_data, shift_en, shift_dir, shadow, busy, done
    );

    modport slave (
`ifdef BCSR_STEP_CTRL_LOOP_EN
        input  loop,
`endif
        input  start, abort, pause, dir, pattern, steps,
        output pre, load_data, shift_en, shift_dir, shadow, busy, done
    );
endinterface

// File: rtl/bcsr_step_ctrl.sv
// Sequencer for a WIDTH-bit circular shift register: one preset load, then a prescaled
// train of shift strobes, then a done pulse. Optional continuous looping: BCSR_STEP_CTRL_LOOP_EN.
//
// state  | meaning
// S_IDLE | waiting for start; captures pattern/steps/dir
// S_LOAD | issue preset strobe, seed shadow and counters
// S_RUN  | prescale countdown, one shift strobe per terminal count
// S_DONE | completion pulse, back to idle
module bcsr_step_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 8,
    parameter int STEPW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bcsr_step_ctrl_if.slave   bus
);

    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PRE_RELOAD = PCW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] pattern_q;
    logic [STEPW-1:0] steps_q;
    logic             dir_q;
    logic [PCW-1:0]   cnt_q;
    logic [STEPW-1:0] rem_q;
    logic [WIDTH-1:0] shadow_q;

    logic             pre_q;
    logic             shift_q;
    logic             busy_q;
    logic             done_q;

    logic             loop_now;
    logic             tick;
    logic             last;

`ifdef BCSR_STEP_CTRL_LOOP_EN
    assign loop_now = bus.loop;
`else
    assign loop_now = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v, input logic right);
        return right ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick    = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (steps_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (!bus.pause && (cnt_q == '0)) begin
                    tick = 1'b1;
                    // remaining count is never 0 in RUN, so 1 marks the final step
                    if (rem_q == STEPW'(1)) begin
                        last = 1'b1;
                        if (!loop_now) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            steps_q   <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            shadow_q  <= '0;
        end else begin
            if ((state_q == S_IDLE) && bus.start && !bus.abort) begin
                pattern_q <= bus.pattern;
                steps_q   <= bus.steps;
                dir_q     <= bus.dir;
            end
            if ((state_q == S_LOAD) && !bus.abort) begin
                shadow_q <= pattern_q;
                cnt_q    <= PRE_RELOAD;
                rem_q    <= steps_q;
            end
            if ((state_q == S_RUN) && !bus.abort && !bus.pause) begin
                if (tick) begin
                    cnt_q    <= PRE_RELOAD;
                    shadow_q <= rotate(shadow_q, dir_q);
                    rem_q    <= (last && loop_now) ? steps_q : rem_q - STEPW'(1);
                end else begin
                    cnt_q <= cnt_q - PCW'(1);
                end
            end
        end
    end

    // Strobes and status are registered, so they trail the state that produced them by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pre_q   <= (state_q == S_LOAD) && !bus.abort;
            shift_q <= tick;
            busy_q  <= (state_q != S_IDLE);
            done_q  <= (state_q == S_DONE) && !bus.abort;
        end
    end

    assign bus.pre       = pre_q;
    assign bus.load_data = pattern_q;
    assign bus.shift_en  = shift_q;
    assign bus.shift_dir = dir_q;
    assign bus.shadow    = shadow_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_bcsr_step_ctrl.sv
// Directed bench for bcsr_step_ctrl at PRESCALE=2; cycle n = values seen just after clock edge n,
// where edge 0 is the edge that samples start.
module tb_bcsr_step_ctrl;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 2;
    localparam int STEPW    = 8;
    localparam int NH       = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcsr_step_ctrl_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

    bcsr_step_ctrl #(
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE),
        .STEPW   (STEPW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0]      pre_m, shift_m, done_m, busy_m;
    logic [WIDTH-1:0] shadow_h [NH];
    logic [WIDTH-1:0] ld_h     [NH];
    logic             dir_h    [NH];
    int               shift_cnt;
    int               done_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic record(input int c);
        if (c < NH) begin
            pre_m[c]    = bus.pre;
            shift_m[c]  = bus.shift_en;
            done_m[c]   = bus.done;
            busy_m[c]   = bus.busy;
            shadow_h[c] = bus.shadow;
            ld_h[c]     = bus.load_data;
            dir_h[c]    = bus.shift_dir;
        end
        if (bus.shift_en) shift_cnt++;
        if (bus.done && done_cyc < 0) done_cyc = c;
    endtask

    task automatic run(input logic [WIDTH-1:0] pat, input logic [STEPW-1:0] st, input logic d,
                       input int ncyc, input int pause_lo, input int pause_hi,
                       input int abort_c, input int start_c);
        pre_m = '0; shift_m = '0; done_m = '0; busy_m = '0;
        shift_cnt = 0;
        done_cyc  = -1;
        bus.pattern = pat;
        bus.steps   = st;
        bus.dir     = d;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        record(0);
        bus.start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            bus.pause = (c >= pause_lo) && (c <= pause_hi);
            bus.abort = (c == abort_c);
            bus.start = (c == start_c);
            @(posedge clk); #1;
            record(c);
        end
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pause   = 1'b0;
        bus.dir     = 1'b0;
        bus.pattern = '0;
        bus.steps   = '0;
`ifdef BCSR_STEP_CTRL_LOOP_EN
        bus.loop    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({bus.pre, bus.load_data, bus.shift_en, bus.shift_dir, bus.shadow, bus.busy, bus.done}),
              64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // basic run: left rotate of 0001 by 3
        run(4'b0001, 8'd3, 1'b0, 10, 0, -1, -1, -1);
        check("t1_pre",    pre_m,   64'h2);
        check("t1_shift",  shift_m, 64'hA8);
        check("t1_done",   done_m,  64'h100);
        check("t1_busy",   busy_m,  64'h1FE);
        check("t1_ld",     64'(ld_h[1]),     64'b0001);
        check("t1_shd1",   64'(shadow_h[1]), 64'b0001);
        check("t1_shd3",   64'(shadow_h[3]), 64'b0010);
        check("t1_shd5",   64'(shadow_h[5]), 64'b0100);
        check("t1_shd7",   64'(shadow_h[7]), 64'b1000);

        // single step both directions, including end-around wrap
        run(4'b1000, 8'd1, 1'b1, 6, 0, -1, -1, -1);
        check("t2r_shift", shift_m, 64'h8);
        check("t2r_done",  done_m,  64'h10);
        check("t2r_dir",   64'(dir_h[2]),    64'd1);
        check("t2r_shd",   64'(shadow_h[3]), 64'b0100);
        run(4'b1000, 8'd1, 1'b0, 6, 0, -1, -1, -1);
        check("t2l_dir",   64'(dir_h[2]),    64'd0);
        check("t2l_shd",   64'(shadow_h[3]), 64'b0001);

        // zero steps: preset then immediate completion
        run(4'b0110, 8'd0, 1'b0, 6, 0, -1, -1, -1);
        check("t3_pre",    pre_m,   64'h2);
        check("t3_shift",  shift_m, 64'h0);
        check("t3_done",   done_m,  64'h4);
        check("t3_busy",   busy_m,  64'h6);
        check("t3_shd",    64'(shadow_h[2]), 64'b0110);

        // pause across cycles 4..7 stretches the gap after the first shift
        run(4'b1011, 8'd4, 1'b0, 17, 4, 7, -1, -1);
        check("t4_shift",  shift_m, 64'h2A08);
        check("t4_done",   done_m,  64'h4000);
        check("t4_busy",   busy_m,  64'h7FFE);
        check("t4_shd7",   64'(shadow_h[7]),  64'b0111);
        check("t4_shd13",  64'(shadow_h[13]), 64'b1011);

        // abort at cycle 4, with a stray start at cycle 3
        run(4'b0110, 8'd4, 1'b1, 12, 0, -1, 4, 3);
        check("t5_pre",    pre_m,   64'h2);
        check("t5_shift",  shift_m, 64'h8);
        check("t5_done",   done_m,  64'h0);
        check("t5_busy",   busy_m,  64'h1E);
        check("t5_shd",    64'(shadow_h[10]), 64'b0011);

        // start and abort together in idle: nothing happens
        bus.pattern = 4'b1111;
        bus.steps   = 8'd2;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5b_idle", 64'({bus.busy, bus.pre, bus.load_data}), 64'({1'b0, 1'b0, 4'b0110}));

        // maximum step count completes without wrapping
        run(4'b0001, 8'd255, 1'b0, 515, 0, -1, -1, -1);
        check("long_shifts", 64'(shift_cnt), 64'd255);
        check("long_done",   64'(done_cyc),  64'd512);

        // asynchronous reset mid-run
        bus.pattern = 4'b0101;
        bus.steps   = 8'd4;
        bus.dir     = 1'b0;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_pre_rst", 64'({bus.busy, bus.shift_en, bus.shadow}), 64'({1'b1, 1'b1, 4'b1010}));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_outputs",
              64'({bus.pre, bus.load_data, bus.shift_en, bus.shift_dir, bus.shadow, bus.busy, bus.done}),
              64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run(4'b0011, 8'd0, 1'b0, 5, 0, -1, -1, -1);
        check("t6_after_pre",  pre_m,  64'h2);
        check("t6_after_done", done_m, 64'h4);

`ifdef BCSR_STEP_CTRL_LOOP_EN
        bus.loop = 1'b1;
        run(4'b0001, 8'd2, 1'b0, 20, 0, -1, 20, -1);
        bus.loop = 1'b0;
        check("loop_shifts", 64'(shift_cnt), 64'd9);
        check("loop_done",   done_m,         64'h0);
        check("loop_pre",    pre_m,          64'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
